uart_tx: RTL and testbench

Buffered 8N1 UART transmitter driving the `usb_tx` pin of the Au+ top level, the outbound counterpart to the `usb_rx` input path. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first, back-to-back, at a fixed baud set by a clock-divider parameter. It replaces the `usb_rx`→`usb_tx` loopback wire once on-chip logic needs to send data to the host.

---
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds an LSB-first serialiser
// with a fixed-divider baud counter. Frames are sent back-to-back while data is queued.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, baud_end;

  // Ready depends only on the registered count, so a pop cannot admit a byte on the same edge.
  assign tx_ready = (count_q != FULL);
  assign push     = tx_valid && tx_ready;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    busy_d  = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Datapath storage carries no reset; its contents are qualified by count and state.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign level = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks/bit) for protocol cases
// and a default-baud instance for bit timing at 868 clocks/bit.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data, tx_data_s;
  logic       tx_valid, tx_valid_s;
  logic       tx_ready, tx_ready_s;
  logic       tx, tx_s;
  logic       busy, busy_s;
  logic [2:0] level, level_s;

  int n_chk = 0;
  int n_err = 0;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .level(level)
  );

  uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s), .tx_valid(tx_valid_s),
    .tx_ready(tx_ready_s), .tx(tx_s), .busy(busy_s), .level(level_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("send_ready", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Start sampling on the first cycle of the start bit; each bit must hold for cpb cycles.
  task automatic rx_frame(input bit slow, input int cpb, input logic [7:0] b, input string tag);
    logic [9:0] fr;
    int hits;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      hits = 0;
      for (int c = 0; c < cpb; c++) begin
        if ((slow ? tx_s : tx) == fr[k]) hits++;
        tick();
      end
      chk($sformatf("%s_bit%0d", tag, k), hits, cpb);
    end
  endtask

  initial begin
    int   cyc, cyc_m, acc6_cyc, rdy_bad, idx;
    logic saw_full, rdy_before;
    logic [2:0] lvl_after6;

    // Reset held with a valid byte presented
    rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
    tx_valid_s = 1'b0; tx_data_s = 8'h00;
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_tx_s", tx_s, 1);
    chk("rst_level_s", level_s, 0);
    tx_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_level", level, 0);
    chk("post_rst_tx", tx, 1);

    // Single byte 0xA5
    send_byte(8'hA5);
    chk("a5_level_e0", level, 1);
    chk("a5_tx_e0", tx, 1);
    tick();
    chk("a5_level_e1", level, 0);
    chk("a5_busy", busy, 1);
    rx_frame(0, 4, 8'hA5, "a5");
    chk("a5_busy_end", busy, 0);
    chk("a5_tx_end", tx, 1);
    tick();

    // Burst 0x01..0x06 with tx_valid held
    saw_full = 1'b0; rdy_bad = 0; acc6_cyc = -1; lvl_after6 = '0;
    fork
      begin
        idx = 1; cyc = 0;
        tx_data = 8'd1; tx_valid = 1'b1;
        while (idx <= 6 && cyc < 400) begin
          rdy_before = tx_ready;
          tick();
          cyc++;
          if (level == 3'd4) saw_full = 1'b1;
          if (tx_ready != (level != 3'd4)) rdy_bad++;
          if (rdy_before) begin
            if (idx == 6) begin
              acc6_cyc   = cyc;
              lvl_after6 = level;
            end
            idx++;
            tx_data = 8'(idx);
            if (idx > 6) tx_valid = 1'b0;
          end
        end
        tx_valid = 1'b0;
      end
      begin
        cyc_m = 0;
        while (tx == 1'b1 && cyc_m < 10) begin
          tick();
          cyc_m++;
        end
        chk("burst_start_lat", cyc_m, 2);
        for (int f = 0; f < 6; f++) rx_frame(0, 4, 8'(f + 1), $sformatf("burst%0d", f + 1));
        chk("burst_busy_end", busy, 0);
        chk("burst_tx_end", tx, 1);
      end
    join
    chk("burst_full_seen", saw_full, 1);
    chk("burst_ready_decode", rdy_bad, 0);
    chk("burst_acc6_edge", acc6_cyc, 43);
    chk("burst_level_after6", lvl_after6, 4);
    tick();

    // Reset pulse during data bit 3 of 0xFF, with another byte queued
    send_byte(8'hFF);
    send_byte(8'hFF);
    repeat (17) tick();
    chk("mid_level_pre", level, 1);
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("mid_post_busy", busy, 0);
    chk("mid_post_tx", tx, 1);
    send_byte(8'h3C);
    tick();
    rx_frame(0, 4, 8'h3C, "x3c");
    chk("x3c_busy_end", busy, 0);
    repeat (4) tick();
    chk("x3c_no_leftover", tx, 1);

    // Default baud, 0x55
    tx_data_s = 8'h55; tx_valid_s = 1'b1;
    tick();
    tx_valid_s = 1'b0;
    chk("slow_level_e0", level_s, 1);
    tick();
    rx_frame(1, 868, 8'h55, "slow");
    chk("slow_busy_end", busy_s, 0);
    chk("slow_tx_end", tx_s, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
